// File: rtl/lcd_write_arbiter.sv
// Two-producer write arbiter for the LCD character port: per-producer FIFOs,
// round-robin selection and an enforced idle gap after every issued write.

module lcd_char_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                       clock,
    input  logic                       resetn,
    input  logic                       push,
    input  logic [7:0]                 din,
    input  logic                       pop,
    input  logic                       ovf_clr,
    output logic [7:0]                 head,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty,
    output logic                       ovf
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          accept;
    logic          drop;

    // Acceptance looks only at the registered count, so a push into a full
    // FIFO is dropped even when a pop frees a slot on the same edge.
    assign accept = push && (count != FULL_CNT);
    assign drop   = push && (count == FULL_CNT);
    assign full   = (count == FULL_CNT);
    assign empty  = (count == '0);
    assign head   = mem[rd_ptr];

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else begin
            if (accept) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (accept && !pop) begin
                count <= count + 1'b1;
            end else if (!accept && pop) begin
                count <= count - 1'b1;
            end
            if (drop) begin
                ovf <= 1'b1;
            end else if (ovf_clr) begin
                ovf <= 1'b0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (accept) begin
            mem[wr_ptr] <= din;
        end
    end
endmodule

module lcd_write_arbiter #(
    parameter int DEPTH      = 4,
    parameter int GAP_CYCLES = 16
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       cpu_we,
    input  logic [7:0] cpu_data,
    input  logic       kbd_we,
    input  logic [7:0] kbd_data,
    input  logic       ovf_clr,
    output logic       cpu_full,
    output logic       kbd_full,
    output logic       cpu_ovf,
    output logic       kbd_ovf,
    output logic       lcd_write_en,
    output logic [7:0] lcd_write_data,
    output logic       busy,
    output logic       state_dbg
);
    localparam int PW  = $clog2(DEPTH);
    localparam int GCW = $clog2(GAP_CYCLES + 1);

    typedef enum logic {
        IDLE = 1'b0,
        GAP  = 1'b1
    } state_t;

    typedef enum logic {
        GRANT_CPU = 1'b0,
        GRANT_KBD = 1'b1
    } grant_t;

    state_t         state;
    state_t         next_state;
    grant_t         last_grant;
    logic [GCW-1:0] gap_cnt;
    logic [GCW-1:0] next_gap;
    logic           cpu_pop;
    logic           kbd_pop;
    logic [7:0]     cpu_head;
    logic [7:0]     kbd_head;
    logic [PW:0]    cpu_count;
    logic [PW:0]    kbd_count;
    logic           cpu_empty;
    logic           kbd_empty;

    lcd_char_fifo #(.DEPTH(DEPTH)) u_cpu_fifo (
        .clock   (clock),
        .resetn  (resetn),
        .push    (cpu_we),
        .din     (cpu_data),
        .pop     (cpu_pop),
        .ovf_clr (ovf_clr),
        .head    (cpu_head),
        .count   (cpu_count),
        .full    (cpu_full),
        .empty   (cpu_empty),
        .ovf     (cpu_ovf)
    );

    lcd_char_fifo #(.DEPTH(DEPTH)) u_kbd_fifo (
        .clock   (clock),
        .resetn  (resetn),
        .push    (kbd_we),
        .din     (kbd_data),
        .pop     (kbd_pop),
        .ovf_clr (ovf_clr),
        .head    (kbd_head),
        .count   (kbd_count),
        .full    (kbd_full),
        .empty   (kbd_empty),
        .ovf     (kbd_ovf)
    );

    // When both FIFOs hold data, the requester that did not win last goes next.
    always_comb begin
        next_state = state;
        next_gap   = gap_cnt;
        cpu_pop    = 1'b0;
        kbd_pop    = 1'b0;
        case (state)
            IDLE: begin
                if (!cpu_empty && (kbd_empty || last_grant == GRANT_KBD)) begin
                    cpu_pop = 1'b1;
                end else if (!kbd_empty) begin
                    kbd_pop = 1'b1;
                end
                if (cpu_pop || kbd_pop) begin
                    next_state = GAP;
                    next_gap   = GCW'(GAP_CYCLES);
                end
            end
            GAP: begin
                next_gap = gap_cnt - 1'b1;
                if (gap_cnt == GCW'(1)) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state          <= IDLE;
            gap_cnt        <= '0;
            last_grant     <= GRANT_KBD;
            lcd_write_en   <= 1'b0;
            lcd_write_data <= 8'h00;
        end else begin
            state        <= next_state;
            gap_cnt      <= next_gap;
            lcd_write_en <= cpu_pop || kbd_pop;
            if (cpu_pop) begin
                lcd_write_data <= cpu_head;
                last_grant     <= GRANT_CPU;
            end else if (kbd_pop) begin
                lcd_write_data <= kbd_head;
                last_grant     <= GRANT_KBD;
            end
        end
    end

    assign busy      = (state != IDLE) || (cpu_count != '0) || (kbd_count != '0);
    assign state_dbg = state;
endmodule

// File: tb/tb_lcd_write_arbiter.sv
// Scoreboard bench for lcd_write_arbiter: drivers queue expected characters,
// a negedge monitor pops and compares every lcd_write_en pulse.

module tb_lcd_write_arbiter;
    localparam int DEPTH      = 4;
    localparam int GAP_CYCLES = 16;
    localparam int PERIOD     = GAP_CYCLES + 1;

    logic       clock;
    logic       resetn;
    logic       cpu_we;
    logic [7:0] cpu_data;
    logic       kbd_we;
    logic [7:0] kbd_data;
    logic       ovf_clr;
    logic       cpu_full;
    logic       kbd_full;
    logic       cpu_ovf;
    logic       kbd_ovf;
    logic       lcd_write_en;
    logic [7:0] lcd_write_data;
    logic       busy;
    logic       state_dbg;

    logic [7:0] exp_q[$];
    int         tests = 0;
    int         fails = 0;
    int         cyc = 0;
    int         last_pulse = -1;
    logic       prev_en = 1'b0;
    logic       check_period = 1'b0;

    lcd_write_arbiter #(.DEPTH(DEPTH), .GAP_CYCLES(GAP_CYCLES)) dut (
        .clock          (clock),
        .resetn         (resetn),
        .cpu_we         (cpu_we),
        .cpu_data       (cpu_data),
        .kbd_we         (kbd_we),
        .kbd_data       (kbd_data),
        .ovf_clr        (ovf_clr),
        .cpu_full       (cpu_full),
        .kbd_full       (kbd_full),
        .cpu_ovf        (cpu_ovf),
        .kbd_ovf        (kbd_ovf),
        .lcd_write_en   (lcd_write_en),
        .lcd_write_data (lcd_write_data),
        .busy           (busy),
        .state_dbg      (state_dbg)
    );

    // clock / cycle counter
    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // drivers: inputs change 1ns after the rising edge
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        repeat (2) tick();
        last_pulse = -1;
        resetn = 1'b1;
        tick();
    endtask

    task automatic push_cpu(input logic [7:0] d);
        cpu_we = 1'b1;
        cpu_data = d;
        tick();
        cpu_we = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < 2000) begin
            tick();
            n++;
        end
        check({name, "_drain_timeout"}, (n >= 2000) ? 1 : 0, 0);
        check({name, "_leftover"}, exp_q.size(), 0);
    endtask

    // monitor / scoreboard
    always @(negedge clock) begin
        if (resetn && lcd_write_en) begin
            check("no_back_to_back", prev_en, 0);
            if (exp_q.size() == 0) begin
                check("unexpected_write", lcd_write_data, 0);
                check("unexpected_pulse", 1, 0);
            end else begin
                check("lcd_write_data", lcd_write_data, exp_q.pop_front());
            end
            if (check_period && last_pulse >= 0)
                check("issue_period", cyc - last_pulse, PERIOD);
            last_pulse = cyc;
        end
        prev_en = lcd_write_en;
    end

    initial begin
        resetn = 1'b0;
        cpu_we = 1'b0;
        cpu_data = 8'h00;
        kbd_we = 1'b0;
        kbd_data = 8'h00;
        ovf_clr = 1'b0;
        #2;
        check("reset_en", lcd_write_en, 0);
        check("reset_data", lcd_write_data, 8'h00);
        check("reset_busy", busy, 0);
        check("reset_flags", {cpu_full, kbd_full, cpu_ovf, kbd_ovf}, 4'b0000);
        do_reset();

        // single write: 2-cycle latency, busy drops GAP_CYCLES after the pulse
        exp_q.push_back(8'h41);
        push_cpu(8'h41);
        check("single_busy", busy, 1);
        @(negedge clock);
        check("single_lat1_en", lcd_write_en, 0);
        @(negedge clock);
        check("single_lat2_en", lcd_write_en, 1);
        check("single_lat2_data", lcd_write_data, 8'h41);
        repeat (GAP_CYCLES - 1) @(negedge clock);
        check("single_busy_hold", busy, 1);
        @(negedge clock);
        check("single_busy_fall", busy, 0);
        check("single_data_held", lcd_write_data, 8'h41);
        drain("single");

        // simultaneous push after reset: cpu first
        do_reset();
        check_period = 1'b1;
        exp_q.push_back(8'h41);
        exp_q.push_back(8'h6B);
        cpu_we = 1'b1; cpu_data = 8'h41;
        kbd_we = 1'b1; kbd_data = 8'h6B;
        tick();
        cpu_we = 1'b0; kbd_we = 1'b0;
        drain("simul");

        // fairness
        do_reset();
        foreach (exp_q[i]) exp_q.delete(i);
        exp_q.push_back(8'h41); exp_q.push_back(8'h61);
        exp_q.push_back(8'h42); exp_q.push_back(8'h62);
        exp_q.push_back(8'h43);
        cpu_we = 1'b1; cpu_data = 8'h41; kbd_we = 1'b1; kbd_data = 8'h61;
        tick();
        cpu_data = 8'h42; kbd_data = 8'h62;
        tick();
        cpu_data = 8'h43; kbd_we = 1'b0;
        tick();
        cpu_we = 1'b0;
        drain("fair");

        // overflow while the arbiter sits in GAP after a kbd write
        do_reset();
        exp_q.push_back(8'h7A);
        kbd_we = 1'b1; kbd_data = 8'h7A;
        tick();
        kbd_we = 1'b0;
        tick();
        check("ovf_in_gap", state_dbg, 1);
        for (int i = 1; i <= 5; i++) begin
            if (i <= DEPTH) exp_q.push_back(8'(i));
            push_cpu(8'(i));
        end
        check("ovf_cpu_full", cpu_full, 1);
        check("ovf_cpu_ovf", cpu_ovf, 1);
        check("ovf_kbd_ovf", kbd_ovf, 0);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check("ovf_clear", cpu_ovf, 0);
        drain("ovf");
        check("ovf_full_after", cpu_full, 0);

        // wrap-around: 10 writes, each only when not full
        do_reset();
        check_period = 1'b0;
        for (int i = 0; i < 10; i++) begin
            int n = 0;
            while (cpu_full && n < 500) begin
                tick();
                n++;
            end
            check("wrap_wait_timeout", (n >= 500) ? 1 : 0, 0);
            exp_q.push_back(8'hA0 + 8'(i));
            push_cpu(8'hA0 + 8'(i));
        end
        drain("wrap");
        check("wrap_no_ovf", cpu_ovf, 0);

        // reset mid-GAP discards queued characters
        do_reset();
        exp_q.push_back(8'h11);
        push_cpu(8'h11);
        push_cpu(8'h12);
        push_cpu(8'h13);
        repeat (4) tick();
        check("rst_in_gap", state_dbg, 1);
        check("rst_busy_before", busy, 1);
        #2;
        resetn = 1'b0;
        exp_q.delete();
        #1;
        check("rst_async_busy", busy, 0);
        check("rst_async_data", lcd_write_data, 8'h00);
        check("rst_async_full", cpu_full, 0);
        tick();
        last_pulse = -1;
        resetn = 1'b1;
        tick();
        exp_q.push_back(8'h55);
        push_cpu(8'h55);
        @(negedge clock);
        check("rst_lat1_en", lcd_write_en, 0);
        @(negedge clock);
        check("rst_lat2_en", lcd_write_en, 1);
        check("rst_lat2_data", lcd_write_data, 8'h55);
        drain("rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/lcd_write_arbiter.md
Name: lcd_write_arbiter

Overview:
- Shares the single character-write port of the LCD controller between two producers: the processor (cpu port) and the keyboard echo path (kbd port).
- Each producer issues one-cycle write strobes. Each producer gets its own small FIFO.
- Buffered characters are forwarded one per slot, round-robin, with an enforced idle gap between writes so the LCD controller can complete each character.
- Sits between the processor/PS2 logic and the lcd instance in the top level.

Parameters:
- DEPTH, 4, entries per requester FIFO; must be a power of 2 and at least 2.
- GAP_CYCLES, 16, idle cycles after each lcd_write_en pulse before the next write may issue; must be at least 1.

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- resetn  in  1  asynchronous, active-low reset.
- cpu_we  in  1  processor write strobe; one push per cycle while high.
- cpu_data  in  8  processor character, sampled when cpu_we is high.
- kbd_we  in  1  keyboard echo write strobe.
- kbd_data  in  8  keyboard character, sampled when kbd_we is high.
- ovf_clr  in  1  synchronous clear of both overflow flags.
- cpu_full  out  1  cpu FIFO holds DEPTH entries.
- kbd_full  out  1  kbd FIFO holds DEPTH entries.
- cpu_ovf  out  1  sticky flag: a cpu push was dropped.
- kbd_ovf  out  1  sticky flag: a kbd push was dropped.
- lcd_write_en  out  1  registered one-cycle write pulse to the LCD controller.
- lcd_write_data  out  8  registered character; valid while lcd_write_en is high, held afterwards.
- busy  out  1  state is not IDLE, or either FIFO is non-empty.

Behaviour:
- Reset (asynchronous, resetn=0):
  - Both FIFOs empty; state IDLE; gap counter 0; last_grant=KBD.
  - All outputs 0, including lcd_write_data=8'h00.
  - Reset asserted mid-GAP or mid-ISSUE aborts the operation; buffered characters are discarded.
- FIFOs:
  - Circular buffers with log2(DEPTH)-bit read/write pointers that wrap modulo DEPTH, plus a count of 0..DEPTH.
  - A push is accepted when the strobe is high and count<DEPTH.
  - A push while full is dropped and sets the sticky ovf flag on that edge. This holds even if a pop of the same FIFO occurs in the same cycle.
  - Push and pop of the same FIFO in one cycle when 0<count<DEPTH: both take effect; count is unchanged.
  - A push into an empty FIFO is not visible to the arbiter until the next cycle; there is no same-cycle bypass.
- ovf_clr:
  - Clears both ovf flags.
  - If an overflowing push occurs in the same cycle, the set wins.
- State machine:
  - IDLE:
    - If exactly one FIFO is non-empty, pop it.
    - If both are non-empty, pop the requester that is not last_grant.
    - On that edge: register lcd_write_en=1 and lcd_write_data=head entry; update last_grant; load gap counter with GAP_CYCLES; go to GAP.
    - If both FIFOs are empty, stay in IDLE with lcd_write_en=0.
  - GAP:
    - lcd_write_en=0.
    - Gap counter decrements each cycle.
    - When the counter reaches 1, go to IDLE on that edge.
- Timing:
  - A push sampled at edge k into empty FIFOs with the arbiter in IDLE produces lcd_write_en high during the cycle after edge k+1, i.e. latency 2 cycles.
  - Issue period is GAP_CYCLES+1 cycles per character: exactly GAP_CYCLES cycles of lcd_write_en=0 between consecutive pulses.
- lcd_write_en is never high in two consecutive cycles.
- Order: characters from one requester are delivered in push order; no duplication, no loss except counted overflow drops.
- busy is a combinational function of state and both counts.

Test Plan:
- Single write: cpu_we pulse with 8'h41 in IDLE → lcd_write_en high for exactly 1 cycle, 2 cycles later, lcd_write_data=8'h41; busy falls after GAP_CYCLES more cycles.
- Simultaneous push after reset: cpu 8'h41 and kbd 8'h6B in the same cycle → output order 41, 6B; pulses spaced GAP_CYCLES+1=17 cycles apart.
- Fairness: cpu pushes 41,42,43 and kbd pushes 61,62 on back-to-back cycles → output order 41,61,42,62,43.
- Overflow: 5 cpu pushes (01..05) on consecutive cycles with DEPTH=4 while the arbiter is held in GAP → cpu_full=1, cpu_ovf=1, output 01,02,03,04 only (05 dropped); ovf_clr → cpu_ovf=0.
- Wrap-around: 10 cpu writes, each pushed only while the FIFO is not full → all 10 characters output in order; pointers wrap twice with no corruption.
- Reset mid-GAP: 3 entries queued, resetn pulsed low during GAP → outputs 0 immediately (asynchronously), FIFOs empty; next push 8'h55 is output with 2-cycle latency.
